decode_writeback: RTL and testbench

- SEQ decode/write-back stage for the Y86-64 processor.
- Holds the 15-entry 64-bit register file. Provides combinational operand reads (valA/valB) for decode and commits valE/valM at the clock edge for write-back.
- Consumes valM/dmem_error from the memory stage, icode/rA/rB/imem_error/instr_valid from fetch, and valE/cnd from execute.
- Also owns the sticky processor status (Stat) and a retired-instruction counter.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/y86_regfile.sv | 46 ++++
 rtl/decode_writeback.sv | 130 +++++++++++++
 tb/tb_decode_writeback.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 SEQ decode/write-back slice.
// Instruction codes, register ids and processor status codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: two async read ports, two write ports, M beats E.
// With WB_FORWARD_EN defined, reads see same-cycle writes (write-first).
module y86_regfile
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      i_src_a,
  input  logic [3:0]      i_src_b,
  input  logic            i_we_e,
  input  logic [3:0]      i_dst_e,
  input  logic [XLEN-1:0] i_val_e,
  input  logic            i_we_m,
  input  logic [3:0]      i_dst_m,
  input  logic [XLEN-1:0] i_val_m,
  output logic [XLEN-1:0] o_rd_a,
  output logic [XLEN-1:0] o_rd_b
);

  logic [XLEN-1:0] r_regs [NREGS];

  // M write is issued last so it overrides E on the same id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (i_we_e) r_regs[i_dst_e] <= i_val_e;
      if (i_we_m) r_regs[i_dst_m] <= i_val_m;
    end
  end

  always_comb begin
    o_rd_a = (i_src_a == RNONE) ? '0 : r_regs[i_src_a];
    o_rd_b = (i_src_b == RNONE) ? '0 : r_regs[i_src_b];
`ifdef WB_FORWARD_EN
    if (i_we_m && i_dst_m == i_src_a)      o_rd_a = i_val_m;
    else if (i_we_e && i_dst_e == i_src_a) o_rd_a = i_val_e;
    if (i_we_m && i_dst_m == i_src_b)      o_rd_b = i_val_m;
    else if (i_we_e && i_dst_e == i_src_b) o_rd_b = i_val_e;
`endif
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back: operand select, commit, sticky Stat, retire count.
// Optional WB_FORWARD_EN macro makes register reads write-first.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int NREGS = 15,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      icode,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic            cnd,
  input  logic [XLEN-1:0] valE,
  input  logic [XLEN-1:0] valM,
  input  logic            imem_error,
  input  logic            instr_valid,
  input  logic            dmem_error,
  output logic [XLEN-1:0] valA,
  output logic [XLEN-1:0] valB,
  output logic [2:0]      stat,
  output logic            halted,
  output logic [63:0]     retired
);

  stat_e       r_stat;
  stat_e       w_stat_nxt;
  logic [63:0] r_retired;
  logic [3:0]  w_src_a;
  logic [3:0]  w_src_b;
  logic [3:0]  w_dst_e;
  logic [3:0]  w_dst_m;
  logic        w_fault;
  logic        w_commit;

  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    unique case (icode)
      IRRMOVQ: begin
        w_src_a = rA;
        if (cnd) w_dst_e = rB;
      end
      IIRMOVQ: w_dst_e = rB;
      IRMMOVQ: begin
        w_src_a = rA;
        w_src_b = rB;
      end
      IMRMOVQ: begin
        w_src_b = rB;
        w_dst_m = rA;
      end
      IOPQ: begin
        w_src_a = rA;
        w_src_b = rB;
        w_dst_e = rB;
      end
      ICALL: begin
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      IRET: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      IPUSHQ: begin
        w_src_a = rA;
        w_src_b = RSP;
        w_dst_e = RSP;
      end
      IPOPQ: begin
        w_src_a = RSP;
        w_src_b = RSP;
        w_dst_e = RSP;
        w_dst_m = rA;
      end
      default: ;
    endcase
  end

  assign w_fault  = imem_error | dmem_error | ~instr_valid;
  assign w_commit = (r_stat == SAOK) && !w_fault;

  y86_regfile #(
    .NREGS(NREGS),
    .XLEN (XLEN)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .i_src_a(w_src_a),
    .i_src_b(w_src_b),
    .i_we_e (w_commit && w_dst_e != RNONE),
    .i_dst_e(w_dst_e),
    .i_val_e(valE),
    .i_we_m (w_commit && w_dst_m != RNONE),
    .i_dst_m(w_dst_m),
    .i_val_m(valM),
    .o_rd_a (valA),
    .o_rd_b (valB)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stat <= SAOK;
    else     r_stat <= w_stat_nxt;
  end

  // Non-AOK states hold until reset
  always_comb begin
    w_stat_nxt = r_stat;
    if (r_stat == SAOK) begin
      if (imem_error || dmem_error) w_stat_nxt = SADR;
      else if (!instr_valid)        w_stat_nxt = SINS;
      else if (icode == IHALT)      w_stat_nxt = SHLT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retired <= '0;
    else if (w_commit) r_retired <= r_retired + 64'd1;
  end

  assign stat    = r_stat;
  assign halted  = (r_stat != SAOK);
  assign retired = r_retired;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: expectations queued at drive time.
// Stat/retired predicted by a small status model; register values from constants.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        imem_error, instr_valid, dmem_error;
  logic [63:0] valA, valB;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  string       q_tag[$];
  logic [63:0] q_exp[$];

  logic [2:0]  m_stat;
  logic [63:0] m_ret;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .cnd        (cnd),
    .valE       (valE),
    .valM       (valM),
    .imem_error (imem_error),
    .instr_valid(instr_valid),
    .dmem_error (dmem_error),
    .valA       (valA),
    .valB       (valB),
    .stat       (stat),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
  endtask

  task automatic pop(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    if (q_tag.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got %0d want queued entry", obs);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      chk(t, obs, e);
    end
  endtask

  // rmmovq reads rA with no destination, so it is a side-effect-free probe
  task automatic expect_reg(input string tag, input logic [3:0] r,
                            input logic [63:0] e);
    push(tag, e);
    icode = 4'h4;
    rA    = r;
    rB    = 4'hF;
    #1;
    pop(valA);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a,
                       input logic [3:0] b, input logic c,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic ie, input logic de, input logic iv);
    @(negedge clk);
    rst = 1'b0;
    icode = ic; rA = a; rB = b; cnd = c;
    valE = ve; valM = vm;
    imem_error = ie; dmem_error = de; instr_valid = iv;
    if (m_stat == 3'd1) begin
      if (ie || de)       m_stat = 3'd3;
      else if (!iv)       m_stat = 3'd4;
      else begin
        m_ret = m_ret + 64'd1;
        if (ic == 4'h0) m_stat = 3'd2;
      end
    end
    push("stat", 64'(m_stat));
    push("retired", m_ret);
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    pop(64'(stat));
    pop(retired);
  endtask

  task automatic reset_now(input string tag);
    rst = 1'b1;
    m_stat = 3'd1;
    m_ret  = '0;
    #1;
    chk({tag, "_stat"}, 64'(stat), 64'd1);
    chk({tag, "_ret"}, retired, 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0;
    imem_error = 1'b0; dmem_error = 1'b0; instr_valid = 1'b1;
    m_stat = 3'd1;
    m_ret  = '0;
    repeat (2) @(negedge clk);
    reset_now("rst0");
    expect_reg("rst_r2", 4'd2, 64'd0);

    drive(4'h3, 4'hF, 4'd2, 1'b0, 64'd100, 64'd0, 1'b0, 1'b0, 1'b1);
    clock();
    expect_reg("irmov_r2", 4'd2, 64'd100);

    drive(4'h6, 4'd2, 4'd2, 1'b0, 64'd300, 64'd0, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef WB_FORWARD_EN
    chk("opq_valA", valA, 64'd300);
    chk("opq_valB", valB, 64'd300);
`else
    chk("opq_valA", valA, 64'd100);
    chk("opq_valB", valB, 64'd100);
`endif
    clock();
    expect_reg("opq_r2", 4'd2, 64'd300);

    drive(4'h2, 4'hF, 4'd5, 1'b0, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1);
    clock();
    expect_reg("cmov_nc_r5", 4'd5, 64'd0);
    drive(4'h2, 4'hF, 4'd5, 1'b1, 64'd7, 64'd0, 1'b0, 1'b0, 1'b1);
    clock();
    expect_reg("cmov_c_r5", 4'd5, 64'd7);

    drive(4'hB, 4'd4, 4'hF, 1'b0, 64'd24, 64'd55, 1'b0, 1'b0, 1'b1);
    clock();
    expect_reg("popq_rsp", 4'd4, 64'd55);

    drive(4'hB, 4'd4, 4'hF, 1'b0, 64'd32, 64'd64, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef WB_FORWARD_EN
    chk("fwd_valA", valA, 64'd64);
`else
    chk("fwd_valA", valA, 64'd55);
`endif
    clock();
    expect_reg("popq2_rsp", 4'd4, 64'd64);

    drive(4'h5, 4'd3, 4'hF, 1'b0, 64'd0, 64'd9, 1'b0, 1'b1, 1'b1);
    clock();
    expect_reg("adr_r3", 4'd3, 64'd0);
    chk("adr_halted", 64'(halted), 64'd1);

    drive(4'h3, 4'hF, 4'd1, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, 1'b1);
    clock();
    expect_reg("after_adr_r1", 4'd1, 64'd0);

    reset_now("rst1");
    expect_reg("rst1_r4", 4'd4, 64'd0);

    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    clock();
    chk("hlt_halted", 64'(halted), 64'd1);
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    clock();
    #2;
    reset_now("rst_mid");

    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    clock();
    reset_now("rst3");
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    clock();

    chk("sb_drained", 64'(q_tag.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
